lstm_cstate_maq: RTL and testbench

Pipelined, multi-lane quantized LSTM cell-state update, c_t = f·c_{t-1} + i·g, on uint8-style asymmetric-quantized operands. Successor to the single-lane combinational cell-state MAQ: parametrised in data width, lane count and rounding mode, registered over three stages with valid/ready flow control, and reporting per-lane saturation plus a saturating event counter. Sits between the sigmoid/tanh activation units and the state register file in the LSTM datapath.

---
 rtl/lstm_q_pkg.sv | 23 ++
 rtl/lstm_cstate_lane.sv | 104 ++++++++++
 rtl/lstm_cstate_maq.sv | 103 ++++++++++
 tb/tb_lstm_cstate_maq.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_q_pkg.sv
// Shared quantization constants for the LSTM MAQ blocks.
// Holds rounding-mode codes, default zero points and scale shifts.
package lstm_q_pkg;

    localparam int ROUND_TRUNC     = 0;
    localparam int ROUND_HALF_AWAY = 1;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_SH_SIG   = 8;
    localparam int DEF_SH_TANH  = 7;
    localparam int DEF_SH_STATE = 7;
    localparam int DEF_Z_SIG    = 0;
    localparam int DEF_Z_TANH   = 128;
    localparam int DEF_Z_STATE  = 128;

    // Shift that brings an i*g product (sigmoid x tanh scale)
    // down to the state scale.
    function automatic int ig_shift(input int sh_sig, input int sh_tanh,
                                    input int sh_state);
        return sh_sig + sh_tanh - sh_state;
    endfunction

endpackage

// File: rtl/lstm_cstate_lane.sv
// One lane of the cell-state update c = f*c + i*g, three registered stages.
// Ports: clk, rst, en1..en3 (stage load enables), f/i/c/g codes in,
//        c_new code out with sat_lo/sat_hi clamp flags.
module lstm_cstate_lane
    import lstm_q_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SH_SIG     = DEF_SH_SIG,
    parameter int SH_TANH    = DEF_SH_TANH,
    parameter int SH_STATE   = DEF_SH_STATE,
    parameter int Z_SIG      = DEF_Z_SIG,
    parameter int Z_TANH     = DEF_Z_TANH,
    parameter int Z_STATE    = DEF_Z_STATE,
    parameter int ROUND_MODE = ROUND_TRUNC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en1,
    input  logic              en2,
    input  logic              en3,
    input  logic [DATA_W-1:0] f,
    input  logic [DATA_W-1:0] i,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] g,
    output logic [DATA_W-1:0] c_new,
    output logic              sat_lo,
    output logic              sat_hi
);

    localparam int DW = DATA_W + 1;
    localparam int PW = 2 * DATA_W + 2;
    localparam int SW = 2 * DATA_W + 3;
    localparam int UW = SW + 1;
    localparam int K1 = SH_SIG;
    localparam int K2 = ig_shift(SH_SIG, SH_TANH, SH_STATE);

    // Zero-point removal, sign-extended to product width.
    function automatic logic signed [PW-1:0] dext(
        input logic [DATA_W-1:0] v,
        input int                z
    );
        logic signed [DW-1:0] d;
        d = $signed({1'b0, v}) - $signed(DW'(z));
        return {{(PW-DW){d[DW-1]}}, d};
    endfunction

    // Sign-magnitude rescale so negative values round symmetrically.
    function automatic logic signed [SW-1:0] rnd(
        input logic signed [PW-1:0] x,
        input int                   k
    );
        logic signed [SW-1:0] xe;
        logic signed [SW-1:0] mag;
        logic signed [SW-1:0] radd;
        xe   = {x[PW-1], x};
        mag  = xe[SW-1] ? -xe : xe;
        radd = '0;
        if (ROUND_MODE == ROUND_HALF_AWAY && k > 0)
            radd = SW'(1) << (k - 1);
        mag = (mag + radd) >> k;
        return xe[SW-1] ? -mag : mag;
    endfunction

    logic signed [PW-1:0] p1;
    logic signed [PW-1:0] p2;
    logic signed [SW-1:0] s;
    logic        [UW-1:0] u;
    logic                 over;

    always_ff @(posedge clk) begin
        if (en1) begin
            p1 <= dext(f, Z_SIG) * dext(c, Z_STATE);
            p2 <= dext(i, Z_SIG) * dext(g, Z_TANH);
        end
    end

    always_ff @(posedge clk) begin
        if (en2)
            s <= rnd(p1, K1) + rnd(p2, K2);
    end

    always_comb begin
        u    = {s[SW-1], s} + UW'(Z_STATE);
        over = !u[UW-1] && (|u[UW-2:DATA_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_new  <= '0;
            sat_lo <= 1'b0;
            sat_hi <= 1'b0;
        end else if (en3) begin
            sat_lo <= u[UW-1];
            sat_hi <= over;
            if (u[UW-1])
                c_new <= '0;
            else if (over)
                c_new <= '1;
            else
                c_new <= u[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/lstm_cstate_maq.sv
// Pipelined multi-lane quantized LSTM cell-state update with valid/ready.
// Ports: clk, rst, in_valid/in_ready, f_q/i_q/c_q/g_q lane-packed codes,
//        out_valid/out_ready, c_new, sat_lo/sat_hi, sat_cnt, cnt_clr.
module lstm_cstate_maq
    import lstm_q_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LANES      = 4,
    parameter int SH_SIG     = DEF_SH_SIG,
    parameter int SH_TANH    = DEF_SH_TANH,
    parameter int SH_STATE   = DEF_SH_STATE,
    parameter int Z_SIG      = DEF_Z_SIG,
    parameter int Z_TANH     = DEF_Z_TANH,
    parameter int Z_STATE    = DEF_Z_STATE,
    parameter int ROUND_MODE = ROUND_TRUNC,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] f_q,
    input  logic [LANES*DATA_W-1:0] i_q,
    input  logic [LANES*DATA_W-1:0] c_q,
    input  logic [LANES*DATA_W-1:0] g_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] c_new,
    output logic [LANES-1:0]        sat_lo,
    output logic [LANES-1:0]        sat_hi,
    output logic [CNT_W-1:0]        sat_cnt,
    input  logic                    cnt_clr
);

    logic v1;
    logic v2;
    logic en1;
    logic en2;
    logic en3;

    // A stage loads when its own slot is free or being drained,
    // so ready ripples back from out_ready without bubbles.
    assign en3      = !out_valid || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
            if (en3) out_valid <= v2;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lstm_cstate_lane #(
            .DATA_W    (DATA_W),
            .SH_SIG    (SH_SIG),
            .SH_TANH   (SH_TANH),
            .SH_STATE  (SH_STATE),
            .Z_SIG     (Z_SIG),
            .Z_TANH    (Z_TANH),
            .Z_STATE   (Z_STATE),
            .ROUND_MODE(ROUND_MODE)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en1   (en1),
            .en2   (en2),
            .en3   (en3),
            .f     (f_q[k*DATA_W +: DATA_W]),
            .i     (i_q[k*DATA_W +: DATA_W]),
            .c     (c_q[k*DATA_W +: DATA_W]),
            .g     (g_q[k*DATA_W +: DATA_W]),
            .c_new (c_new[k*DATA_W +: DATA_W]),
            .sat_lo(sat_lo[k]),
            .sat_hi(sat_hi[k])
        );
    end

    logic [CNT_W:0] inc;
    logic [CNT_W:0] sum;

    always_comb begin
        inc = '0;
        for (int k = 0; k < LANES; k++)
            inc = inc + (CNT_W+1)'(sat_lo[k] | sat_hi[k]);
        sum = {1'b0, sat_cnt} + inc;
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            sat_cnt <= '0;
        else if (out_valid && out_ready)
            sat_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

endmodule

// File: tb/tb_lstm_cstate_maq.sv
// Self-checking bench for lstm_cstate_maq, both rounding modes side by side.
// Directed test-plan cases, stall/reset/clear scenarios and a random stream.
module tb_lstm_cstate_maq;

    localparam int L  = 4;
    localparam int DW = 8;
    localparam int VW = L * DW;

    typedef struct {
        logic [VW-1:0] f;
        logic [VW-1:0] c;
        logic [VW-1:0] i;
        logic [VW-1:0] g;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic          cnt_clr;
    logic [VW-1:0] f_q, i_q, c_q, g_q;

    logic          ir0, ir1, ov0, ov1;
    logic [VW-1:0] cn0, cn1;
    logic [L-1:0]  lo0, lo1, hi0, hi1;
    logic [15:0]   cnt0, cnt1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lstm_cstate_maq #(.ROUND_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir0),
        .f_q(f_q), .i_q(i_q), .c_q(c_q), .g_q(g_q),
        .out_valid(ov0), .out_ready(out_ready),
        .c_new(cn0), .sat_lo(lo0), .sat_hi(hi0),
        .sat_cnt(cnt0), .cnt_clr(cnt_clr)
    );

    lstm_cstate_maq #(.ROUND_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir1),
        .f_q(f_q), .i_q(i_q), .c_q(c_q), .g_q(g_q),
        .out_valid(ov1), .out_ready(out_ready),
        .c_new(cn1), .sat_lo(lo1), .sat_hi(hi1),
        .sat_cnt(cnt1), .cnt_clr(cnt_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference: scale-domain arithmetic on plain integers.
    function automatic int rq(input int x, input int k, input int mode);
        int m;
        int r;
        m = (x < 0) ? -x : x;
        if (k == 0)        r = m;
        else if (mode == 0) r = m / (1 << k);
        else               r = (m + (1 << (k - 1))) / (1 << k);
        return (x < 0) ? -r : r;
    endfunction

    task automatic ref_beat(input beat_t b, input int mode,
                            output logic [VW-1:0] cv,
                            output logic [L-1:0] lo,
                            output logic [L-1:0] hi);
        int fv, cvv, iv, gv, u;
        for (int k = 0; k < L; k++) begin
            fv  = int'(b.f[k*DW +: DW]);
            cvv = int'(b.c[k*DW +: DW]);
            iv  = int'(b.i[k*DW +: DW]);
            gv  = int'(b.g[k*DW +: DW]);
            u = rq(fv * (cvv - 128), 8, mode)
              + rq(iv * (gv - 128), 8 + 7 - 7, mode) + 128;
            lo[k] = (u < 0);
            hi[k] = (u > 255);
            if (u < 0)        cv[k*DW +: DW] = 8'd0;
            else if (u > 255) cv[k*DW +: DW] = 8'd255;
            else              cv[k*DW +: DW] = DW'(u);
        end
    endtask

    beat_t         q[$];
    int            mc0 = 0;
    int            mc1 = 0;
    logic          stall_prev = 1'b0;
    logic [VW-1:0] hold_c;
    logic [L-1:0]  hold_lo, hold_hi;
    logic          saw_block = 1'b0;
    beat_t         pb;
    logic [VW-1:0] e0, e1;
    logic [L-1:0]  el0, eh0, el1, eh1;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mc0 = 0;
            mc1 = 0;
            stall_prev = 1'b0;
        end else begin
            chk("in_ready_m0", ir0, !(q.size() == 3 && !out_ready));
            chk("in_ready_m1", ir1, !(q.size() == 3 && !out_ready));
            chk("sat_cnt_m0", cnt0, mc0);
            chk("sat_cnt_m1", cnt1, mc1);
            if (in_valid && !ir0) saw_block = 1'b1;
            if (stall_prev) begin
                chk("hold_valid", ov0, 1);
                chk("hold_c_new", cn0, hold_c);
                chk("hold_flags", {lo0, hi0}, {hold_lo, hold_hi});
            end
            stall_prev = ov0 && !out_ready;
            hold_c  = cn0;
            hold_lo = lo0;
            hold_hi = hi0;
            if (ov0 && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", ov0, 0);
                end else begin
                    pb = q.pop_front();
                    ref_beat(pb, 0, e0, el0, eh0);
                    ref_beat(pb, 1, e1, el1, eh1);
                    chk("c_new_m0", cn0, e0);
                    chk("sat_lo_m0", lo0, el0);
                    chk("sat_hi_m0", hi0, eh0);
                    chk("out_valid_m1", ov1, 1);
                    chk("c_new_m1", cn1, e1);
                    chk("sat_lo_m1", lo1, el1);
                    chk("sat_hi_m1", hi1, eh1);
                    if (!cnt_clr) begin
                        mc0 += $countones(el0 | eh0);
                        mc1 += $countones(el1 | eh1);
                        if (mc0 > 65535) mc0 = 65535;
                        if (mc1 > 65535) mc1 = 65535;
                    end
                end
            end
            if (cnt_clr) begin
                mc0 = 0;
                mc1 = 0;
            end
            if (in_valid && ir0)
                q.push_back('{f: f_q, c: c_q, i: i_q, g: g_q});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [VW-1:0] vf, input logic [VW-1:0] vc,
                        input logic [VW-1:0] vi, input logic [VW-1:0] vg);
        logic acc;
        int   n;
        f_q = vf; c_q = vc; i_q = vi; g_q = vg;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = ir0;
            step();
            n++;
        end while (!acc && n < 200);
        chk("send_accept", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send({$urandom}, {$urandom}, {$urandom}, {$urandom});
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!ov0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("out_seen", ov0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    localparam logic [VW-1:0] NC = {4{8'd128}};

    int  lat;
    bit  rnd_done;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        f_q = '0; c_q = '0; i_q = '0; g_q = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", ov0, 0);
        chk("rst_c_new", cn0, 0);
        chk("rst_sat", {lo0, hi0}, 0);
        chk("rst_sat_cnt", cnt0, 0);
        chk("rst_in_ready", ir0, 1);
        step();

        // f=255 c=200 i=0 g=128 on lane 0, neutral lanes elsewhere
        send({24'd0, 8'd255}, {24'h808080, 8'd200}, '0, NC);
        wait_out(lat);
        chk("latency", lat, 3);
        chk("case1_m0", cn0[7:0], 199);
        chk("case1_m1", cn1[7:0], 200);
        chk("case1_sat", {lo0[0], hi0[0]}, 0);
        chk("case1_lane1", cn0[15:8], 128);
        step();

        send({24'd0, 8'd128}, {24'h808080, 8'd0},
             {24'd0, 8'd255}, {24'h808080, 8'd0});
        wait_out(lat);
        chk("case2_m0", cn0[7:0], 0);
        chk("case2_lo_m0", lo0[0], 1);
        chk("case2_m1", cn1[7:0], 0);
        chk("case2_lo_m1", lo1[0], 1);
        step();
        @(negedge clk);
        chk("case2_cnt", cnt0, 1);
        step();

        send('1, '1, '1, '1);
        wait_out(lat);
        chk("case3_c_new", cn0, 32'hFFFF_FFFF);
        chk("case3_hi", hi0, 4'hF);
        step();
        @(negedge clk);
        chk("case3_cnt", cnt0, 5);
        step();

        send({8'd0, 8'd255, 8'd10, 8'd200}, {8'd77, 8'd250, 8'd250, 8'd100},
             {8'd128, 8'd255, 8'd100, 8'd50}, {8'd64, 8'd250, 8'd100, 8'd200});
        wait_out(lat);
        chk("case4_m0", cn0, {8'd96, 8'd255, 8'd122, 8'd121});
        chk("case4_m1", cn1, {8'd96, 8'd255, 8'd122, 8'd120});
        chk("case4_hi", hi0, 4'b0100);
        step();
        @(negedge clk);
        chk("case4_cnt", cnt0, 6);
        step();

        // 8-beat stream with a 5-cycle downstream stall
        saw_block = 1'b0;
        fork
            begin
                for (int n = 0; n < 8; n++) send_rand();
            end
            begin
                out_ready = 1'b1;
                repeat (3) step();
                out_ready = 1'b0;
                repeat (5) step();
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_blocked", saw_block, 1);

        // random stream with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    if ($urandom_range(3) == 0) step();
                    send_rand();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(2) != 0);
                    step();
                end
            end
        join
        drain();

        // reset with two beats in flight
        send_rand();
        send_rand();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("rst_flush", ov0, 0);
        end
        chk("rst_cnt_zero", cnt0, 0);
        step();
        send('0, NC, '0, NC);
        wait_out(lat);
        chk("rst_latency", lat, 3);
        chk("rst_beat", cn0, NC);
        step();
        drain();

        // clear arriving together with a clamping beat
        send('1, '1, '1, '1);
        drain();
        step();
        @(negedge clk);
        chk("pre_clr_cnt", cnt0, 4);
        step();
        send('1, '1, '1, '1);
        step();
        step();
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("clr_out_valid", ov0, 1);
        step();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_wins_m0", cnt0, 0);
        chk("clr_wins_m1", cnt1, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
